hls_deadlock_axis_monitor_param: RTL and testbench
==================================================

// Module: hls_deadlock_axis_monitor_param
// PURPOSE
//  Parametrised per-level deadlock monitor for HLS dataflow regions: N_AXIS stream-block lines, N_INST instance lines.
//  Adds to the fixed 3-channel monitor: persistence filter (THRESH cycles), optional sticky latch with clear,
//  first-blocked-channel capture and a saturating block-event counter. Instantiated per dataflow level;
//  its block output feeds the parent level's sub_block_in.
// PARAMETERS
//  N_AXIS     3   number of axis block lines (>=1)
//  N_INST     2   number of instance idle/block lines (>=1)
//  SELF_MASK  1   N_AXIS-bit mask: set bits = this level's own channels; clear bits = child-level channels
//  USE_INST   0   1: instance stall term contributes to raw block
//  THRESH     1   consecutive raw-block cycles before block asserts (>=1; 0 illegal)
//  STICKY     0   1: block/info/first held after raw drops, until clear
//  CNT_W      8   width of block_events
// PORTS
//  clock            in   1              rising-edge clock
//  reset            in   1              asynchronous, active-low reset
//  axis_block_sigs  in   N_AXIS         per-channel stream block
//  inst_idle_sigs   in   N_INST         per-instance idle
//  inst_block_sigs  in   N_INST         per-instance block
//  sub_block_in     in   1              block from child-level monitor
//  clear            in   1              sync clear of state/info/counters
//  axis_block_info  out  N_AXIS*N_AXIS  per-channel info field, zero unless block=1
//  block            out  1              deadlock declared
//  first_valid      out  1              first_axis valid
//  first_axis       out  AW             AW = N_AXIS>1 ? clog2(N_AXIS) : 1; lowest blocked channel at declaration
//  block_events     out  CNT_W          count of block declarations, saturating
// BEHAVIOUR
//  raw = |(axis & SELF_MASK) | (sub_block_in & |(axis & ~SELF_MASK))
//        | (USE_INST & |inst_block_sigs & ~&inst_idle_sigs); combinational, not an output.
//  Reset (reset=0, async, no edge needed): all outputs 0, FSM=IDLE, pcnt=0.
//  FSM registered, states IDLE/SUSPECT/BLOCKED/LATCHED; pcnt counts consecutive raw cycles.
//   IDLE:    raw -> SUSPECT (pcnt=1); if THRESH=1 go directly to BLOCKED.
//   SUSPECT: !raw -> IDLE, pcnt=0; raw & pcnt==THRESH-1 -> BLOCKED; else pcnt++.
//   BLOCKED: !raw -> IDLE if STICKY=0, else LATCHED; raw -> stay.
//   LATCHED: exit only via clear or reset.
//  block = (state==BLOCKED|LATCHED), registered. raw high on edges 1..THRESH -> block high after edge THRESH.
//  THRESH=1 reproduces the legacy one-cycle registered monitor.
//  info_reg field i (bits [i*N_AXIS +: N_AXIS]) = axis[i] ? ~(1<<i) : 0, sampled every edge.
//  STICKY=1: info_reg freezes on the edge entering BLOCKED, until clear.
//  axis_block_info = block ? info_reg : 0.
//  On the edge entering BLOCKED: first_axis = lowest set index of axis; first_valid = |axis.
//  Both hold while BLOCKED/LATCHED; zeroed on return to IDLE. Same edge: block_events++, saturating at all-ones.
//  clear: beats raw; next edge -> IDLE, pcnt, info_reg, first_*, block_events = 0. Raw during clear cycle ignored.
//  Reset mid-operation: immediate return to reset values. Counting restarts from 0 after reset release.
//  Raw dropping for one cycle in SUSPECT: pcnt restarts. No partial credit.
// TESTING
//  1 THRESH=4, axis=3'b001 held -> block=0 after edges 1-3, =1 after edge 4; info=9'h006, first_axis=0, first_valid=1, events=1
//  2 THRESH=4, axis=3'b001 for 3 cycles then 0 -> block never asserts, events=0; 3-cycle repeat pattern also never asserts
//  3 SELF_MASK=3'b001, axis=3'b100, sub=0 -> no block; sub=1 for THRESH cycles -> block=1, info=9'h0C0, first_axis=2
//  4 STICKY=1: declare on axis=3'b010 (info=9'h028), drop raw -> block=1, info=9'h028 held; clear pulse -> all 0 next edge
//  5 CNT_W=2, THRESH=1: 5 separate raw pulses with idle gaps -> block_events=1,2,3,3,3
//  6 Assert reset=0 mid-BLOCKED between edges -> block, info, first_*, events 0 at once; release, raw high -> re-declare after THRESH edges

Source files
------------

// File: rtl/hls_deadlock_axis_monitor_param.sv
// Per-level deadlock monitor for an HLS dataflow region. A persistence filter turns the
// raw stall term into a block declaration, with optional sticky latch, first-channel capture and event count.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no raw block seen on the previous edge
// ST_SUSPECT | raw block seen for pcnt consecutive edges, below THRESH
// ST_BLOCKED | deadlock declared, raw still high
// ST_LATCHED | deadlock declared, raw has dropped; held until clear/reset
module hls_deadlock_axis_monitor_param #(
    parameter int unsigned       N_AXIS    = 3,
    parameter int unsigned       N_INST    = 2,
    parameter logic [N_AXIS-1:0] SELF_MASK = N_AXIS'(1),
    parameter bit                USE_INST  = 1'b0,
    parameter int unsigned       THRESH    = 1,
    parameter bit                STICKY    = 1'b0,
    parameter int unsigned       CNT_W     = 8,
    localparam int unsigned      AW        = (N_AXIS > 1) ? $clog2(N_AXIS) : 1
) (
    input  logic                       clock_i,
    input  logic                       reset_ni,
    input  logic [N_AXIS-1:0]          axis_block_sigs_i,
    input  logic [N_INST-1:0]          inst_idle_sigs_i,
    input  logic [N_INST-1:0]          inst_block_sigs_i,
    input  logic                       sub_block_in_i,
    input  logic                       clear_i,
    output logic [N_AXIS*N_AXIS-1:0]   axis_block_info_o,
    output logic                       block_o,
    output logic                       first_valid_o,
    output logic [AW-1:0]              first_axis_o,
    output logic [CNT_W-1:0]           block_events_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_BLOCKED = 2'd2,
        ST_LATCHED = 2'd3
    } state_e;

    localparam int unsigned   PW        = (THRESH > 1) ? $clog2(THRESH) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(THRESH - 1);

    state_e                      state_q, state_d;
    logic [PW-1:0]               pcnt_q, pcnt_d;
    logic [N_AXIS*N_AXIS-1:0]    info_q, info_d;
    logic                        first_valid_q;
    logic [AW-1:0]               first_axis_q, first_axis_d;
    logic [CNT_W-1:0]            events_q;
    logic                        raw;
    logic                        block_w;
    logic                        enter_blk;
    logic                        to_idle;

    // Child-level channels only count when the child monitor itself reports a block.
    always_comb begin
        raw = |(axis_block_sigs_i & SELF_MASK);
        raw = raw | (sub_block_in_i & |(axis_block_sigs_i & ~SELF_MASK));
        if (USE_INST) begin
            raw = raw | (|inst_block_sigs_i & ~&inst_idle_sigs_i);
        end
    end

    always_comb begin
        info_d = '0;
        for (int i = 0; i < N_AXIS; i++) begin
            if (axis_block_sigs_i[i]) begin
                info_d[i*N_AXIS +: N_AXIS] = ~(N_AXIS'(1) << i);
            end
        end
    end

    always_comb begin
        first_axis_d = '0;
        for (int i = N_AXIS - 1; i >= 0; i--) begin
            if (axis_block_sigs_i[i]) begin
                first_axis_d = AW'(i);
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        if (clear_i) begin
            state_d = ST_IDLE;
            pcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (raw) begin
                        if (THRESH == 1) begin
                            state_d = ST_BLOCKED;
                            pcnt_d  = '0;
                        end else begin
                            state_d = ST_SUSPECT;
                            pcnt_d  = PW'(1);
                        end
                    end
                end
                ST_SUSPECT: begin
                    if (!raw) begin
                        state_d = ST_IDLE;
                        pcnt_d  = '0;
                    end else if (pcnt_q == PCNT_LAST) begin
                        state_d = ST_BLOCKED;
                        pcnt_d  = '0;
                    end else begin
                        pcnt_d = pcnt_q + PW'(1);
                    end
                end
                ST_BLOCKED: begin
                    if (!raw) begin
                        state_d = STICKY ? ST_LATCHED : ST_IDLE;
                        pcnt_d  = '0;
                    end
                end
                ST_LATCHED: begin
                    state_d = ST_LATCHED;
                end
                default: begin
                    state_d = ST_IDLE;
                    pcnt_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        block_w   = (state_q == ST_BLOCKED) || (state_q == ST_LATCHED);
        enter_blk = (state_d == ST_BLOCKED) && (state_q != ST_BLOCKED);
        to_idle   = (state_d == ST_IDLE);
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            info_q        <= '0;
            first_valid_q <= 1'b0;
            first_axis_q  <= '0;
            events_q      <= '0;
        end else if (clear_i) begin
            info_q        <= '0;
            first_valid_q <= 1'b0;
            first_axis_q  <= '0;
            events_q      <= '0;
        end else begin
            // A sticky monitor keeps the snapshot taken at declaration.
            if (!(STICKY && block_w)) begin
                info_q <= info_d;
            end
            if (enter_blk) begin
                first_valid_q <= |axis_block_sigs_i;
                first_axis_q  <= first_axis_d;
                if (!(&events_q)) begin
                    events_q <= events_q + CNT_W'(1);
                end
            end else if (to_idle) begin
                first_valid_q <= 1'b0;
                first_axis_q  <= '0;
            end
        end
    end

    assign block_o           = block_w;
    assign axis_block_info_o = block_w ? info_q : '0;
    assign first_valid_o     = first_valid_q;
    assign first_axis_o      = first_axis_q;
    assign block_events_o    = events_q;

endmodule

// File: tb/tb_hls_deadlock_axis_monitor_param.sv
// Four monitor variants share one stimulus stream; each is checked every cycle
// against a run-length reference model, plus directed scenario checks.
module tb_hls_deadlock_axis_monitor_param;

    localparam logic [2:0] P_MASK [4] = '{3'b111, 3'b001, 3'b011, 3'b111};
    localparam int         P_TH   [4] = '{4, 3, 2, 1};
    localparam bit         P_ST   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    localparam bit         P_UI   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    localparam int         P_CW   [4] = '{8, 8, 8, 2};

    logic       clk;
    logic       rst_n;
    logic [2:0] axis;
    logic [1:0] idle;
    logic [1:0] iblk;
    logic       sub;
    logic       clr;

    logic [8:0] info [4];
    logic       blk  [4];
    logic       fv   [4];
    logic [1:0] fa   [4];
    logic [7:0] ev   [4];

    int         run    [4];
    bit         mblk   [4];
    logic [8:0] minfo  [4];
    int         mfirst [4];
    bit         mfv    [4];
    int         mev    [4];

    int n_chk = 0;
    int n_err = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic [P_CW[g]-1:0] ev_w;
        hls_deadlock_axis_monitor_param #(
            .N_AXIS   (3),
            .N_INST   (2),
            .SELF_MASK(P_MASK[g]),
            .USE_INST (P_UI[g]),
            .THRESH   (P_TH[g]),
            .STICKY   (P_ST[g]),
            .CNT_W    (P_CW[g])
        ) u_dut (
            .clock_i          (clk),
            .reset_ni         (rst_n),
            .axis_block_sigs_i(axis),
            .inst_idle_sigs_i (idle),
            .inst_block_sigs_i(iblk),
            .sub_block_in_i   (sub),
            .clear_i          (clr),
            .axis_block_info_o(info[g]),
            .block_o          (blk[g]),
            .first_valid_o    (fv[g]),
            .first_axis_o     (fa[g]),
            .block_events_o   (ev_w)
        );
        assign ev[g] = 8'(ev_w);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] info_of(input logic [2:0] a);
        logic [8:0] r;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            if (a[i]) r[i*3 +: 3] = 3'(~(3'b001 << i));
        end
        return r;
    endfunction

    function automatic int lowest(input logic [2:0] a);
        for (int i = 0; i < 3; i++) begin
            if (a[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < 4; g++) begin
            run[g] = 0; mblk[g] = 0; minfo[g] = '0; mfirst[g] = 0; mfv[g] = 0; mev[g] = 0;
        end
    endtask

    // Block means "raw has been high for at least THRESH consecutive edges"
    // (or, when sticky, "has been at some point since the last clear").
    task automatic model_edge();
        for (int g = 0; g < 4; g++) begin
            bit raw, was, decl;
            raw = ((axis & P_MASK[g]) != 0) || (sub && ((axis & ~P_MASK[g]) != 0))
                  || (P_UI[g] && iblk != 0 && idle != 2'b11);
            if (clr) begin
                run[g] = 0; mblk[g] = 0; minfo[g] = '0; mfirst[g] = 0; mfv[g] = 0; mev[g] = 0;
            end else begin
                was    = mblk[g];
                run[g] = raw ? ((run[g] < P_TH[g]) ? run[g] + 1 : run[g]) : 0;
                mblk[g] = P_ST[g] ? (was || run[g] >= P_TH[g]) : (run[g] >= P_TH[g]);
                decl   = mblk[g] && !was;
                if (!(P_ST[g] && was)) minfo[g] = info_of(axis);
                if (decl) begin
                    mfirst[g] = lowest(axis);
                    mfv[g]    = (axis != 0);
                    if (mev[g] < (1 << P_CW[g]) - 1) mev[g]++;
                end else if (!mblk[g]) begin
                    mfirst[g] = 0;
                    mfv[g]    = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("blk%0d", g), blk[g], mblk[g]);
            chk($sformatf("info%0d", g), info[g], mblk[g] ? minfo[g] : 9'h0);
            chk($sformatf("first%0d", g), fa[g], mfirst[g]);
            chk($sformatf("fvalid%0d", g), fv[g], mfv[g]);
            chk($sformatf("events%0d", g), ev[g], mev[g]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        int t5 [5] = '{1, 2, 3, 3, 3};
        rst_n = 1'b0; axis = '0; idle = '0; iblk = '0; sub = 1'b0; clr = 1'b0;
        model_reset();
        #12;
        compare_all();
        rst_n = 1'b1;

        // sustained block on channel 0 with THRESH=4
        axis = 3'b001;
        repeat (3) tick();
        chk("t1_blk_pre", blk[0], 1'b0);
        tick();
        chk("t1_blk", blk[0], 1'b1);
        chk("t1_info", info[0], 9'h006);
        chk("t1_first", fa[0], 2'd0);
        chk("t1_fvalid", fv[0], 1'b1);
        chk("t1_events", ev[0], 8'd1);
        axis = 3'b000;
        tick();

        // runs one short of THRESH never declare
        do_clear();
        repeat (3) begin
            axis = 3'b001;
            repeat (3) tick();
            axis = 3'b000;
            tick();
        end
        chk("t2_events", ev[0], 8'd0);

        // child channel needs sub_block_in
        do_clear();
        axis = 3'b100; sub = 1'b0;
        repeat (4) tick();
        chk("t3_noblk", blk[1], 1'b0);
        sub = 1'b1;
        repeat (3) tick();
        chk("t3_blk", blk[1], 1'b1);
        chk("t3_info", info[1], 9'h0C0);
        chk("t3_first", fa[1], 2'd2);
        sub = 1'b0; axis = 3'b000;
        tick();

        // sticky latch and clear
        do_clear();
        axis = 3'b010;
        repeat (2) tick();
        chk("t4_info", info[2], 9'h028);
        axis = 3'b000;
        repeat (2) tick();
        chk("t4_held_blk", blk[2], 1'b1);
        chk("t4_held_info", info[2], 9'h028);
        do_clear();
        chk("t4_clr_blk", blk[2], 1'b0);
        chk("t4_clr_info", info[2], 9'h000);
        chk("t4_clr_events", ev[2], 8'd0);

        // saturating 2-bit counter
        for (int k = 0; k < 5; k++) begin
            axis = 3'b001;
            tick();
            axis = 3'b000;
            tick();
            chk($sformatf("t5_events_%0d", k), ev[3], t5[k]);
        end

        // async reset while blocked
        do_clear();
        axis = 3'b001;
        repeat (4) tick();
        chk("t6_pre_blk", blk[0], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_blk", blk[0], 1'b0);
        chk("t6_rst_events", ev[0], 8'd0);
        compare_all();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t6_re_pre", blk[0], 1'b0);
        tick();
        chk("t6_re_blk", blk[0], 1'b1);

        // randomized soak
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(3) == 0) axis = 3'($urandom);
            idle = 2'($urandom);
            iblk = 2'($urandom);
            sub  = ($urandom_range(3) != 0);
            clr  = ($urandom_range(31) == 0);
            if ($urandom_range(199) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_all();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
